// File: rtl/vo_src_arb.sv
// Frame-synchronous two-source pixel arbiter with a one-stage registered output.
// Optional statistics counters are enabled with `define VO_SRC_ARB_STATS_EN.
module vo_src_arb #(
   parameter logic [23:0] FILL_RGB    = 24'h000000,
   parameter bit          SEL_DEFAULT = 1'b0
) (
   input  logic        vo_clk,
   input  logic        vo_reset,
   input  logic        sel,
   input  logic        src0_valid,
   input  logic        src0_eol,
   input  logic        src0_eof,
   input  logic [23:0] src0_pixel,
   output logic        src0_ready,
   input  logic        src1_valid,
   input  logic        src1_eol,
   input  logic        src1_eof,
   input  logic [23:0] src1_pixel,
   output logic        src1_ready,
   input  logic        out_ready,
   output logic        out_req,
   output logic        out_eol,
   output logic        out_eof,
   output logic [23:0] out_pixel,
   output logic        active_sel,
   output logic        syncing,
   output logic        underrun,
`ifdef VO_SRC_ARB_STATS_EN
   output logic [15:0] frame_cnt,
   output logic [15:0] underrun_cnt,
`endif
   input  logic        underrun_clr
);

   typedef enum logic [0:0] {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        active_sel_q, active_sel_d;
   logic        out_req_q, out_req_d;
   logic        out_eol_q, out_eol_d;
   logic        out_eof_q, out_eof_d;
   logic [23:0] out_pixel_q, out_pixel_d;
   logic        underrun_q, underrun_d;

   logic        load;
   logic        cur_valid;
   logic        cur_eol;
   logic        cur_eof;
   logic [23:0] cur_pixel;
   logic        consume;
   logic        fill;

   assign load = out_ready || !out_req_q;

   always_comb begin
      if (active_sel_q) begin
         cur_valid = src1_valid;
         cur_eol   = src1_eol;
         cur_eof   = src1_eof;
         cur_pixel = src1_pixel;
      end else begin
         cur_valid = src0_valid;
         cur_eol   = src0_eol;
         cur_eof   = src0_eof;
         cur_pixel = src0_pixel;
      end
   end

   assign consume    = load && cur_valid;
   // Readiness is gated by reset so nothing is popped while the block is held.
   assign src0_ready = !vo_reset && load && !active_sel_q;
   assign src1_ready = !vo_reset && load &&  active_sel_q;

   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      out_req_d    = out_req_q;
      out_eol_d    = out_eol_q;
      out_eof_d    = out_eof_q;
      out_pixel_d  = out_pixel_q;
      underrun_d   = underrun_q && !underrun_clr;
      fill         = 1'b0;

      unique case (state_q)
         ST_SYNC: begin
            if (load) begin
               out_req_d = 1'b0;
               out_eol_d = 1'b0;
               out_eof_d = 1'b0;
            end
            // A source switch restarts the drain; an eof seen in that cycle belongs to the old source.
            if (sel != active_sel_q) begin
               active_sel_d = sel;
            end else if (consume && cur_eof) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load) begin
               out_req_d = 1'b1;
               if (cur_valid) begin
                  out_eol_d   = cur_eol;
                  out_eof_d   = cur_eof;
                  out_pixel_d = cur_pixel;
                  if (cur_eof && (sel != active_sel_q)) begin
                     active_sel_d = sel;
                     state_d      = ST_SYNC;
                  end
               end else begin
                  out_eol_d   = 1'b0;
                  out_eof_d   = 1'b0;
                  out_pixel_d = FILL_RGB;
                  underrun_d  = 1'b1;
                  fill        = 1'b1;
               end
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge vo_clk) begin
      if (vo_reset) begin
         state_q      <= ST_SYNC;
         active_sel_q <= SEL_DEFAULT;
         out_req_q    <= 1'b0;
         out_eol_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         out_pixel_q  <= '0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_sel_q <= active_sel_d;
         out_req_q    <= out_req_d;
         out_eol_q    <= out_eol_d;
         out_eof_q    <= out_eof_d;
         out_pixel_q  <= out_pixel_d;
         underrun_q   <= underrun_d;
      end
   end

   assign out_req    = out_req_q;
   assign out_eol    = out_eol_q;
   assign out_eof    = out_eof_q;
   assign out_pixel  = out_pixel_q;
   assign active_sel = active_sel_q;
   assign syncing    = (state_q == ST_SYNC);
   assign underrun   = underrun_q;

`ifdef VO_SRC_ARB_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] underrun_cnt_q, underrun_cnt_d;

   always_comb begin
      frame_cnt_d    = frame_cnt_q;
      underrun_cnt_d = underrun_cnt_q;
      if (out_req_q && out_eof_q && out_ready) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (fill) begin
         if (underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
         end
      end else if (underrun_clr) begin
         underrun_cnt_d = '0;
      end
   end

   always_ff @(posedge vo_clk) begin
      if (vo_reset) begin
         frame_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else begin
         frame_cnt_q    <= frame_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_cnt_q;
`else
   logic unused_fill;
   assign unused_fill = fill;
`endif

endmodule

// File: doc/vo_src_arb.md
Name: vo_src_arb

Overview:
- Frame-synchronous pixel source arbiter/sequencer in front of the video output timing block, in the vo_clk domain.
- Selects one of two pixel sources, for example a test-pattern generator (src0) and a framebuffer reader (src1).
- Forwards that source's pixel/eol/eof stream to the video output through a one-stage registered pipeline.
- Source changes take effect only on frame boundaries. Underruns are covered with a fill colour and flagged.

Parameters:
- FILL_RGB, 24'h000000, pixel driven on underrun; {B[23:16],G[15:8],R[7:0]}.
- SEL_DEFAULT, 0, value of active_sel after reset.

Ports:
- vo_clk  in  1  pixel clock
- vo_reset  in  1  synchronous, active-high reset
- sel  in  1  requested source; sampled only at frame boundaries
- src0_valid  in  1  src0 beat available
- src0_eol  in  1  src0 beat is last pixel of line
- src0_eof  in  1  src0 beat is last pixel of frame
- src0_pixel  in  24  src0 pixel
- src0_ready  out  1  src0 beat consumed this cycle (valid && ready)
- src1_valid, src1_eol, src1_eof, src1_pixel, src1_ready  same as src0
- out_ready  in  1  sink consumes current out_* beat this cycle
- out_req  out  1  out_* holds a beat
- out_eol  out  1  last pixel of line
- out_eof  out  1  last pixel of frame
- out_pixel  out  24  pixel to video output
- active_sel  out  1  source currently routed
- syncing  out  1  high in SYNC state
- underrun  out  1  sticky: fill beat was issued
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset (vo_reset=1 at posedge, any state):
  - state=SYNC, active_sel=SEL_DEFAULT.
  - out_req/out_eol/out_eof=0, out_pixel=0, underrun=0.
  - srcN_ready is combinational and therefore 0 while reset is asserted.
- Pipeline: load = out_ready || !out_req. out_* registers update only when load=1, so latency from source beat to out_* is 1 cycle. Unselected source: ready=0 always.
- SYNC: drains the selected source to a frame boundary.
  - src_ready[active_sel]=load; beats are discarded.
  - Each load cycle writes out_req=0.
  - A consumed beat with eof=1 moves to RUN on the next cycle.
  - sel changes in SYNC: active_sel<=sel immediately and draining continues on the new source; an eof consumed in the same cycle is ignored.
- RUN: src_ready[active_sel]=load.
  - load with valid=1: out_req<=1; out_eol/out_eof/out_pixel copy the source beat.
  - load with valid=0 (underrun): out_req<=1, out_pixel<=FILL_RGB, out_eol<=0, out_eof<=0, underrun<=1. The source is not popped.
  - Consumed eof beat with sel==active_sel: stay in RUN.
  - Consumed eof beat with sel!=active_sel: active_sel<=sel, go to SYNC. The eof beat itself is still forwarded.
- underrun: if underrun_clr and a set event occur in the same cycle, set wins.
- syncing = (state==SYNC), registered-state decode.
- eol and eof may both be high on the same beat; eof alone also counts as a frame boundary.

Optional Feature:
- Macro: VO_SRC_ARB_STATS_EN.
- Defined: adds output ports frame_cnt[15:0] and underrun_cnt[15:0], both reset to 0.
  - frame_cnt increments on each out_eof beat consumed by the sink (out_req && out_eof && out_ready); wraps 16'hFFFF->0.
  - underrun_cnt increments per fill beat loaded; saturates at 16'hFFFF; cleared by underrun_clr, with increment winning if both occur in the same cycle.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, sel=0, src0 presents 3 beats then an eof beat with pixel 24'h123456, out_ready=1 -> first 4 beats discarded (out_req=0, syncing=1); next src0 beat appears on out_* 1 cycle after acceptance; syncing=0.
- RUN on src0, out_ready toggles 1/0, src0 always valid -> srcN_ready=load; no beat lost or duplicated; out_* stable while out_req=1 && out_ready=0.
- RUN, src0_valid=0 for 2 load cycles -> two beats with out_pixel=FILL_RGB and eol/eof=0; underrun=1 until underrun_clr; src0 not popped.
- RUN on src0, sel->1 mid-frame -> src0 continues through its eof beat (forwarded); then active_sel=1, SYNC drains src1 up to its eof, then RUN on src1.
- vo_reset pulsed mid-line in RUN -> next cycle out_req=0, state SYNC, active_sel=SEL_DEFAULT, underrun=0.
- With VO_SRC_ARB_STATS_EN: 3 frames forwarded with 5 fill beats -> frame_cnt=3, underrun_cnt=5; underrun_clr -> underrun_cnt=0.
